// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the pipeline writeback and an auxiliary multi-cycle unit (mul/div).
//
// Ports:
//   clk, clr                 clock and synchronous active-high reset
//   pipe_valid/flush/rd/wdata pipeline writeback request
//   pipe_stall               registered: pipeline must hold its request
//   aux_req/rd/wdata         auxiliary request, held until aux_ack
//   aux_ack                  combinational: aux request consumed this cycle
//   rf_wb                    registered write bus {we, data[31:0], addr[4:0]}
//
// Build option: define WB_ARB_STARVE_GUARD_EN to force the aux request onto
// the port after STARVE_LIMIT consecutive contended cycles. Without it the
// pipeline has strict priority and pipe_stall is tied low.

module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pipe_valid,
    input  logic        pipe_flush,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        aux_req,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_wdata,
    output logic        aux_ack,
    output logic [37:0] rf_wb
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_chk
        $error("wb_port_arbiter: STARVE_LIMIT must be 1..7");
    end

    // A flushed pipeline request is neither written nor contending.
    logic pipe_eff;
    assign pipe_eff = pipe_valid & ~pipe_flush;

    logic take_pipe;
    logic take_aux;

`ifdef WB_ARB_STARVE_GUARD_EN

    localparam logic [0:0] NORMAL    = 1'b0;
    localparam logic [0:0] FORCE_AUX = 1'b1;
    localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);

    logic [0:0] state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       stall_q, stall_d;
    logic [2:0] cnt_inc;

    assign cnt_inc = wait_cnt_q + 3'd1;

    always_comb begin
        take_pipe  = 1'b0;
        take_aux   = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        if (state_q == FORCE_AUX) begin
            // Pipeline is stalled: flush is ignored, its request stays held.
            // A withdrawn aux request simply writes nothing.
            take_aux   = aux_req;
            state_d    = NORMAL;
            stall_d    = 1'b0;
            wait_cnt_d = 3'd0;
        end else if (pipe_eff) begin
            take_pipe = 1'b1;
            if (aux_req) begin
                wait_cnt_d = cnt_inc;
                if (cnt_inc == LIMIT) begin
                    state_d = FORCE_AUX;
                    stall_d = 1'b1;
                end
            end else begin
                wait_cnt_d = 3'd0;
            end
        end else begin
            take_aux   = aux_req;
            wait_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= NORMAL;
            wait_cnt_q <= 3'd0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign pipe_stall = stall_q;

`else

    always_comb begin
        take_pipe = pipe_eff;
        take_aux  = ~pipe_eff & aux_req;
    end

    assign pipe_stall = 1'b0;

`endif

    // Reset consumes nothing, so the handshake is masked during clr.
    assign aux_ack = take_aux & ~clr;

    logic [37:0] rf_wb_q, rf_wb_d;

    // Writes to r0 still update data/address but never assert the enable.
    always_comb begin
        rf_wb_d = {1'b0, rf_wb_q[36:0]};
        if (take_pipe) begin
            rf_wb_d = {|pipe_rd, pipe_wdata, pipe_rd};
        end else if (take_aux) begin
            rf_wb_d = {|aux_rd, aux_wdata, aux_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rf_wb_q <= 38'd0;
        end else begin
            rf_wb_q <= rf_wb_d;
        end
    end

    assign rf_wb = rf_wb_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
// Covers the default build and, when the guard macro is defined, forcing.

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        pipe_valid;
    logic        pipe_flush;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        aux_req;
    logic [4:0]  aux_rd;
    logic [31:0] aux_wdata;
    logic        aux_ack;
    logic [37:0] rf_wb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .pipe_valid (pipe_valid),
        .pipe_flush (pipe_flush),
        .pipe_rd    (pipe_rd),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .aux_req    (aux_req),
        .aux_rd     (aux_rd),
        .aux_wdata  (aux_wdata),
        .aux_ack    (aux_ack),
        .rf_wb      (rf_wb)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wb(input logic en, input logic [31:0] d,
                                       input logic [4:0] a);
        return {26'd0, en, d, a};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic f,
                            input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v;
        pipe_flush = f;
        pipe_rd    = rd;
        pipe_wdata = d;
    endtask

    task automatic set_aux(input logic r, input logic [4:0] rd,
                           input logic [31:0] d);
        aux_req   = r;
        aux_rd    = rd;
        aux_wdata = d;
    endtask

    initial begin
        clr = 1'b1;
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        cyc();
        cyc();
        chk("reset_wb", 64'(rf_wb), 64'd0);
        chk("reset_stall", 64'(pipe_stall), 64'd0);
        clr = 1'b0;

        // Pipeline-only write
        set_pipe(1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        #1;
        chk("pipe_ack", 64'(aux_ack), 64'd0);
        cyc();
        chk("pipe_wb", 64'(rf_wb), wb(1'b1, 32'hDEADBEEF, 5'd5));

        // Idle cycle holds data/address, drops enable
        set_pipe(1'b0, 1'b0, 5'd1, 32'h0);
        cyc();
        chk("idle_hold", 64'(rf_wb), wb(1'b0, 32'hDEADBEEF, 5'd5));

        // Aux-only write
        set_aux(1'b1, 5'd9, 32'h12345678);
        #1;
        chk("aux_ack", 64'(aux_ack), 64'd1);
        cyc();
        chk("aux_wb", 64'(rf_wb), wb(1'b1, 32'h12345678, 5'd9));
        set_aux(1'b0, 5'd0, 32'd0);

        // Flushed pipe request is not written
        set_pipe(1'b1, 1'b1, 5'd7, 32'hAAAA5555);
        cyc();
        chk("flush_wb", 64'(rf_wb), wb(1'b0, 32'h12345678, 5'd9));

        // Flushed pipe does not block aux
        set_aux(1'b1, 5'd12, 32'hC0FFEE00);
        #1;
        chk("flush_aux_ack", 64'(aux_ack), 64'd1);
        cyc();
        chk("flush_aux_wb", 64'(rf_wb), wb(1'b1, 32'hC0FFEE00, 5'd12));
        set_aux(1'b0, 5'd0, 32'd0);

        // Write to r0 updates bus but not enable
        set_pipe(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        cyc();
        chk("r0_wb", 64'(rf_wb), wb(1'b0, 32'hFFFFFFFF, 5'd0));
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        cyc();

`ifdef WB_ARB_STARVE_GUARD_EN
        // Contention: 4 pipe writes, then one forced aux cycle
        set_aux(1'b1, 5'd3, 32'hA0A0A0A0);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1'b1, 1'b0, 5'(10 + k), 32'h100 + k);
            #1;
            chk("starve_ack", 64'(aux_ack), 64'd0);
            cyc();
            chk("starve_wb", 64'(rf_wb), wb(1'b1, 32'h100 + k, 5'(10 + k)));
            chk("starve_stall", 64'(pipe_stall), 64'(k == 4));
        end
        // Forced cycle; a flush here must be ignored
        set_pipe(1'b1, 1'b1, 5'd15, 32'h105);
        #1;
        chk("force_ack", 64'(aux_ack), 64'd1);
        cyc();
        chk("force_wb", 64'(rf_wb), wb(1'b1, 32'hA0A0A0A0, 5'd3));
        chk("force_stall", 64'(pipe_stall), 64'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 1'b0, 5'd15, 32'h105);
        cyc();
        chk("held_wb", 64'(rf_wb), wb(1'b1, 32'h105, 5'd15));
        set_pipe(1'b1, 1'b0, 5'd16, 32'h106);
        cyc();
        chk("resume_wb", 64'(rf_wb), wb(1'b1, 32'h106, 5'd16));

        // Reset during the forced cycle abandons the grant
        set_aux(1'b1, 5'd4, 32'hB0B0B0B0);
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 1'b0, 5'd20, 32'h200 + k);
            cyc();
        end
        chk("clr_pre_stall", 64'(pipe_stall), 64'd1);
        clr = 1'b1;
        #1;
        chk("clr_ack", 64'(aux_ack), 64'd0);
        cyc();
        chk("clr_wb", 64'(rf_wb), 64'd0);
        chk("clr_stall", 64'(pipe_stall), 64'd0);
        clr = 1'b0;
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("clr_later_ack", 64'(aux_ack), 64'd1);
        cyc();
        chk("clr_later_wb", 64'(rf_wb), wb(1'b1, 32'hB0B0B0B0, 5'd4));

        // Aux withdrawn during the forced cycle: no write
        set_aux(1'b1, 5'd6, 32'h66);
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 1'b0, 5'd21, 32'h300 + k);
            cyc();
        end
        set_aux(1'b0, 5'd6, 32'h66);
        cyc();
        chk("withdraw_wb", 64'(rf_wb), wb(1'b0, 32'h303, 5'd21));
        chk("withdraw_stall", 64'(pipe_stall), 64'd0);
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
`else
        // Strict priority: aux waits while pipeline is busy
        set_aux(1'b1, 5'd3, 32'hA0A0A0A0);
        for (int k = 0; k < 20; k++) begin
            set_pipe(1'b1, 1'b0, 5'(k + 1), 32'h1000 + k);
            #1;
            chk("prio_ack", 64'(aux_ack), 64'd0);
            cyc();
            chk("prio_wb", 64'(rf_wb), wb(1'b1, 32'h1000 + k, 5'(k + 1)));
            chk("prio_stall", 64'(pipe_stall), 64'd0);
        end
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("prio_drop_ack", 64'(aux_ack), 64'd1);
        cyc();
        chk("prio_drop_wb", 64'(rf_wb), wb(1'b1, 32'hA0A0A0A0, 5'd3));
        set_aux(1'b0, 5'd0, 32'd0);
`endif

        // Reset takes priority over a live request
        set_pipe(1'b1, 1'b0, 5'd8, 32'h88888888);
        set_aux(1'b1, 5'd2, 32'h22);
        clr = 1'b1;
        #1;
        chk("clr_prio_ack", 64'(aux_ack), 64'd0);
        cyc();
        chk("clr_prio_wb", 64'(rf_wb), 64'd0);
        clr = 1'b0;
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
